// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 1280x720 raster timing generator with registered sync, active, coordinate and strobe outputs
// Optional frame counter output: define VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        clk75MHz,
    input  logic        rst_n,
    input  logic        en,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hcnt;
    logic [9:0]  vcnt;
    logic        act_d;
    logic        hs_d;
    logic        vs_d;
    logic        h_wrap;

    always_comb begin
        act_d  = (hcnt < H_VIS) && (vcnt < V_VIS);
        hs_d   = (hcnt >= HS_START) && (hcnt < HS_END);
        // vsync decodes vcnt only, so its edges land where hcnt wraps to 0
        vs_d   = (vcnt >= VS_START) && (vcnt < VS_END);
        h_wrap = (hcnt == H_LAST);
    end

    always_ff @(posedge clk75MHz or negedge rst_n) begin
        if (!rst_n) begin
            hcnt        <= '0;
            vcnt        <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            active      <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hsync       <= hs_d ? HS_POL : ~HS_POL;
            vsync       <= vs_d ? VS_POL : ~VS_POL;
            active      <= act_d;
            pix_x       <= act_d ? hcnt : '0;
            pix_y       <= act_d ? vcnt : '0;
            line_start  <= (hcnt == '0);
            frame_start <= (hcnt == '0) && (vcnt == '0);
            if (h_wrap) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 11'd1;
            end
        end else begin
            // frozen raster: levels hold, strobes must not repeat
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk75MHz or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen (short vertical raster)
module tb_vga_timing_gen;

    localparam int H_TOT  = 1650;
    localparam int V_ACT  = 6;
    localparam int V_TOT  = 13;
    localparam int FRAME  = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        hsync, vsync, active, line_start, frame_start;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt;
`endif

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(3), .V_BP(2)
    ) dut (
        .clk75MHz   (clk),
        .rst_n      (rst_n),
        .en         (en),
        .hsync      (hsync),
        .vsync      (vsync),
        .active     (active),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .line_start (line_start),
        .frame_start(frame_start)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) step();
        nvec++;
        if ({hsync, vsync, active, pix_x, pix_y, line_start, frame_start} !== 26'd0) begin
            nfail++;
            $display("FAIL reset_state: got hs=%b vs=%b act=%b x=%0d y=%0d ls=%b fs=%b, want all 0",
                     hsync, vsync, active, pix_x, pix_y, line_start, frame_start);
        end
    endtask

    task automatic test_first_pixel();
        do_reset();
        step();
        nvec++;
        if ({frame_start, line_start, active, pix_x, pix_y} !== {3'b111, 21'd0}) begin
            nfail++;
            $display("FAIL first_pixel: got fs=%b ls=%b act=%b x=%0d y=%0d, want 1 1 1 0 0",
                     frame_start, line_start, active, pix_x, pix_y);
        end
        step();
        nvec++;
        if ({frame_start, line_start, active, pix_x} !== {3'b001, 11'd1}) begin
            nfail++;
            $display("FAIL second_pixel: got fs=%b ls=%b act=%b x=%0d, want 0 0 1 1",
                     frame_start, line_start, active, pix_x);
        end
    endtask

    task automatic test_line();
        int act_cnt = 0, hs_cnt = 0, hs_first = -1, ls_cnt = 0;
        logic [10:0] x_last = '0;
        logic        act_after = 1'b1;
        do_reset();
        for (int i = 0; i < H_TOT; i++) begin
            step();
            if (active) act_cnt++;
            if (hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
            if (line_start) ls_cnt++;
            if (i == 1279) x_last = pix_x;
            if (i == 1280) act_after = active;
        end
        nvec++;
        if (act_cnt != 1280) begin nfail++; $display("FAIL line_active_count: got %0d want 1280", act_cnt); end
        nvec++;
        if (hs_cnt != 40) begin nfail++; $display("FAIL hsync_width: got %0d want 40", hs_cnt); end
        nvec++;
        if (hs_first != 1390) begin nfail++; $display("FAIL hsync_start: got %0d want 1390", hs_first); end
        nvec++;
        if (ls_cnt != 1) begin nfail++; $display("FAIL line_start_count: got %0d want 1", ls_cnt); end
        nvec++;
        if (x_last !== 11'd1279 || act_after !== 1'b0) begin
            nfail++;
            $display("FAIL active_edge: got x=%0d act_after=%b want 1279 0", x_last, act_after);
        end
        step();
        nvec++;
        if ({line_start, frame_start, active, pix_x, pix_y} !== {3'b101, 11'd0, 10'd1}) begin
            nfail++;
            $display("FAIL line_period: got ls=%b fs=%b act=%b x=%0d y=%0d want 1 0 1 0 1",
                     line_start, frame_start, active, pix_x, pix_y);
        end
    endtask

    task automatic test_frame();
        int act_cnt = 0, vs_cnt = 0, vs_first = -1, vs_last = -1, ls_cnt = 0, fs_cnt = 0;
        logic [9:0] y_max = '0;
        do_reset();
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (active) act_cnt++;
            if (vsync) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = i;
                vs_last = i;
            end
            if (line_start) ls_cnt++;
            if (frame_start) fs_cnt++;
            if (pix_y > y_max) y_max = pix_y;
        end
        nvec++;
        if (act_cnt != 1280 * V_ACT) begin nfail++; $display("FAIL frame_active_count: got %0d want %0d", act_cnt, 1280 * V_ACT); end
        nvec++;
        if (vs_cnt != 3 * H_TOT) begin nfail++; $display("FAIL vsync_width: got %0d want %0d", vs_cnt, 3 * H_TOT); end
        nvec++;
        if (vs_first != 8 * H_TOT || vs_last != 11 * H_TOT - 1) begin
            nfail++;
            $display("FAIL vsync_edges: got %0d..%0d want %0d..%0d", vs_first, vs_last, 8 * H_TOT, 11 * H_TOT - 1);
        end
        nvec++;
        if (ls_cnt != V_TOT || fs_cnt != 1) begin
            nfail++;
            $display("FAIL strobe_counts: got ls=%0d fs=%0d want %0d 1", ls_cnt, fs_cnt, V_TOT);
        end
        nvec++;
        if (y_max !== 10'(V_ACT - 1)) begin nfail++; $display("FAIL pix_y_max: got %0d want %0d", y_max, V_ACT - 1); end
        step();
        nvec++;
        if ({frame_start, line_start, active, pix_x, pix_y, vsync} !== {3'b111, 21'd0, 1'b0}) begin
            nfail++;
            $display("FAIL frame_wrap: got fs=%b ls=%b act=%b x=%0d y=%0d vs=%b want 1 1 1 0 0 0",
                     frame_start, line_start, active, pix_x, pix_y, vsync);
        end
`ifdef VGA_FRAME_COUNT_EN
        nvec++;
        if (frame_cnt !== 16'd1) begin nfail++; $display("FAIL frame_cnt: got %0d want 1", frame_cnt); end
`endif
    endtask

    task automatic test_freeze();
        int changes = 0, strobes = 0;
        do_reset();
        step();
        en = 1'b0;
        step();
        nvec++;
        if ({frame_start, line_start, active, pix_x} !== {3'b001, 11'd0}) begin
            nfail++;
            $display("FAIL freeze_at_start: got fs=%b ls=%b act=%b x=%0d want 0 0 1 0",
                     frame_start, line_start, active, pix_x);
        end
        en = 1'b1;
        step();
        nvec++;
        if ({line_start, pix_x} !== {1'b0, 11'd1}) begin
            nfail++;
            $display("FAIL resume_no_dup: got ls=%b x=%0d want 0 1", line_start, pix_x);
        end
        repeat (498) step();
        en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (pix_x !== 11'd499 || active !== 1'b1) changes++;
            if (line_start || frame_start) strobes++;
        end
        nvec++;
        if (changes != 0 || strobes != 0) begin
            nfail++;
            $display("FAIL freeze_hold: got %0d changes %0d strobes want 0 0", changes, strobes);
        end
        en = 1'b1;
        step();
        nvec++;
        if (pix_x !== 11'd500) begin nfail++; $display("FAIL resume_x0: got %0d want 500", pix_x); end
        step();
        nvec++;
        if (pix_x !== 11'd501) begin nfail++; $display("FAIL resume_x1: got %0d want 501", pix_x); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (4 * H_TOT + 901) step();
        nvec++;
        if ({active, pix_x, pix_y} !== {1'b1, 11'd900, 10'd4}) begin
            nfail++;
            $display("FAIL pre_reset_pos: got act=%b x=%0d y=%0d want 1 900 4", active, pix_x, pix_y);
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({hsync, vsync, active, pix_x, pix_y, line_start, frame_start} !== 26'd0) begin
            nfail++;
            $display("FAIL async_reset: got act=%b x=%0d y=%0d, want all 0", active, pix_x, pix_y);
        end
        repeat (3) step();
        rst_n = 1'b1;
        step();
        nvec++;
        if ({frame_start, line_start, active, pix_x, pix_y} !== {3'b111, 21'd0}) begin
            nfail++;
            $display("FAIL restart: got fs=%b ls=%b x=%0d y=%0d want 1 1 0 0",
                     frame_start, line_start, pix_x, pix_y);
        end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_line();
        test_frame();
        test_freeze();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
